// File: rtl/ysyx_22040088_memarbiter_if.sv
// Bus bundle for the memory arbiter: IFU and LSU request ports plus the shared memory port.
// master = arbiter view; slave = requesters/memory view.
interface ysyx_22040088_memarbiter_if;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;

  logic        lsu_req;
  logic        lsu_wen;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [3:0]  lsu_mask;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [63:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_22040088_memarbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction outstanding.
// state   | meaning
// IDLE    | no transaction; grant combinationally, latch payload on the grant edge
// IF_REQ  | fetch request on memory port, waiting for mem_ready
// IF_WAIT | fetch accepted, waiting for mem_rvalid
// LS_REQ  | load/store request on memory port (or one-cycle error response if misaligned)
// LS_WAIT | load/store accepted, waiting for mem_rvalid
module ysyx_22040088_memarbiter (
  input  logic clk,
  input  logic rst_n,
  ysyx_22040088_memarbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    LS_REQ  = 3'd3,
    LS_WAIT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        last_lsu;
  logic        pick_lsu, pick_ifu;
  logic        lsu_misalign;
  logic [7:0]  lsu_strb;
  logic [63:0] pay_addr;
  logic [63:0] pay_wdata;
  logic [7:0]  pay_wstrb;
  logic        pay_wen;
  logic        pay_err;
  logic        pay_hi;
  logic        ifu_addr_unused;

  // Fetch addresses are word aligned, so their two low bits carry nothing.
  assign ifu_addr_unused = ^bus.ifu_addr[1:0];

  always_comb begin
    pick_lsu = bus.lsu_req && (!bus.ifu_req || !last_lsu);
    pick_ifu = bus.ifu_req && !pick_lsu;
  end

  always_comb begin
    lsu_misalign = 1'b0;
    lsu_strb     = 8'h00;
    case (bus.lsu_mask)
      4'b0001: begin
        lsu_misalign = |bus.lsu_addr[2:0];
        lsu_strb     = 8'hff;
      end
      4'b0010: begin
        lsu_misalign = |bus.lsu_addr[1:0];
        lsu_strb     = 8'h0f << {bus.lsu_addr[2], 2'b00};
      end
      4'b0100: begin
        lsu_misalign = bus.lsu_addr[0];
        lsu_strb     = 8'h03 << {bus.lsu_addr[2:1], 1'b0};
      end
      4'b1000: lsu_strb = 8'h01 << bus.lsu_addr[2:0];
      default: lsu_misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Payload is captured on the grant edge; wdata/strobes are lane-shifted here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_addr  <= 64'd0;
      pay_wdata <= 64'd0;
      pay_wstrb <= 8'h00;
      pay_wen   <= 1'b0;
      pay_err   <= 1'b0;
      pay_hi    <= 1'b0;
      last_lsu  <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_lsu) begin
        pay_addr  <= {bus.lsu_addr[63:3], 3'b000};
        pay_wdata <= bus.lsu_wen ? (bus.lsu_wdata << {bus.lsu_addr[2:0], 3'b000}) : 64'd0;
        pay_wstrb <= bus.lsu_wen ? lsu_strb : 8'h00;
        pay_wen   <= bus.lsu_wen;
        pay_err   <= lsu_misalign;
        pay_hi    <= 1'b0;
        last_lsu  <= 1'b1;
      end else if (pick_ifu) begin
        pay_addr  <= {bus.ifu_addr[63:3], 3'b000};
        pay_wdata <= 64'd0;
        pay_wstrb <= 8'h00;
        pay_wen   <= 1'b0;
        pay_err   <= 1'b0;
        pay_hi    <= bus.ifu_addr[2];
        last_lsu  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_lsu)      state_nxt = LS_REQ;
        else if (pick_ifu) state_nxt = IF_REQ;
      end
      IF_REQ:  if (bus.mem_ready) state_nxt = IF_WAIT;
      IF_WAIT: if (bus.mem_rvalid) state_nxt = IDLE;
      LS_REQ: begin
        if (pay_err)            state_nxt = IDLE;
        else if (bus.mem_ready) state_nxt = LS_WAIT;
      end
      LS_WAIT: if (bus.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ifu_gnt    = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = 32'd0;
    bus.lsu_gnt    = 1'b0;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_rdata  = 64'd0;
    bus.lsu_err    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_addr   = 64'd0;
    bus.mem_wdata  = 64'd0;
    bus.mem_wstrb  = 8'h00;
    case (state)
      // Grants are gated by rst_n so nothing leaks out while reset is held.
      IDLE: begin
        bus.ifu_gnt = rst_n && pick_ifu;
        bus.lsu_gnt = rst_n && pick_lsu;
      end
      IF_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pay_addr;
      end
      IF_WAIT: begin
        bus.ifu_rvalid = bus.mem_rvalid;
        if (bus.mem_rvalid) bus.ifu_rdata = pay_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end
      LS_REQ: begin
        if (pay_err) begin
          bus.lsu_rvalid = 1'b1;
          bus.lsu_err    = 1'b1;
        end else begin
          bus.mem_req   = 1'b1;
          bus.mem_wen   = pay_wen;
          bus.mem_addr  = pay_addr;
          bus.mem_wdata = pay_wdata;
          bus.mem_wstrb = pay_wstrb;
        end
      end
      LS_WAIT: begin
        bus.lsu_rvalid = bus.mem_rvalid;
        if (bus.mem_rvalid) bus.lsu_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040088_memarbiter.sv
// Scoreboard bench for the memory arbiter: directed scenarios, then randomized IFU/LSU traffic.
module tb_ysyx_22040088_memarbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040088_memarbiter_if bus();
  ysyx_22040088_memarbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          err;
    bit          chk_data;
    logic [63:0] rdata;
    int          gcyc;
  } rsp_t;

  typedef struct {
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } mreq_t;

  rsp_t  ifu_q[$];
  rsp_t  lsu_q[$];
  mreq_t mem_q[$];
  bit    gnt_log[$];

  int n_chk = 0, n_err = 0, cyc = 0;
  bit busy = 0, last_lsu = 0, chk_lat = 0;
  int ready_pct = 100, dly_min = 0, dly_max = 0, hold_cnt = 0;
  bit spur_en = 0;
  bit resp_pending = 0, resp_real = 0, mem_fire = 0;
  int resp_cnt = 0;
  logic [63:0] resp_addr = 64'd0;
  bit prev_stall = 0;
  int stall_run = 0, max_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00500093_00000013;
    return {a[31:0] ^ 32'h1357_9bdf, ~a[31:0]};
  endfunction

  function automatic int size_of(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Memory: random ready, fixed-range response delay, optional spurious rvalid.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      mem_fire = 0;
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_word(resp_addr);
          mem_fire = resp_real;
          resp_pending = 0;
        end else resp_cnt--;
      end else if (spur_en && $urandom_range(7) == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
      end
      if (hold_cnt > 0) begin
        bus.mem_ready = 1'b0;
        hold_cnt--;
      end else bus.mem_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {bus.ifu_gnt, bus.ifu_rvalid, bus.lsu_gnt, bus.lsu_rvalid, bus.lsu_err, bus.mem_req, bus.mem_wen}, 64'd0);
      chk("reset_data", bus.mem_addr | bus.mem_wdata | bus.lsu_rdata | {32'd0, bus.ifu_rdata} | {56'd0, bus.mem_wstrb}, 64'd0);
      ifu_q.delete(); lsu_q.delete(); mem_q.delete();
      busy = 0; last_lsu = 0; prev_stall = 0; stall_run = 0; resp_real = 0;
    end else begin
      bit exp_lg, exp_ig;
      rsp_t r;
      mreq_t m;
      int n, off;
      logic [63:0] w;
      exp_lg = !busy && bus.lsu_req && (!bus.ifu_req || !last_lsu);
      exp_ig = !busy && bus.ifu_req && !exp_lg;
      if (bus.ifu_req || bus.lsu_req || bus.ifu_gnt || bus.lsu_gnt)
        chk("grant", {62'd0, bus.lsu_gnt, bus.ifu_gnt}, {62'd0, exp_lg, exp_ig});
      if (bus.lsu_gnt) begin
        n = size_of(bus.lsu_mask);
        off = int'(bus.lsu_addr % 64'd8);
        if (n == 0) r.err = 1;
        else r.err = (bus.lsu_addr % 64'(n)) != 64'd0;
        r.chk_data = r.err || !bus.lsu_wen;
        r.rdata = r.err ? 64'd0 : mem_word(bus.lsu_addr & ~64'h7);
        r.gcyc = cyc;
        lsu_q.push_back(r);
        if (!r.err) begin
          m.addr = bus.lsu_addr & ~64'h7;
          m.wen = bus.lsu_wen;
          m.wdata = bus.lsu_wdata << (8 * off);
          m.wstrb = bus.lsu_wen ? 8'(((1 << n) - 1) << off) : 8'h00;
          mem_q.push_back(m);
        end
        busy = 1; last_lsu = 1; gnt_log.push_back(1'b1);
      end
      if (bus.ifu_gnt) begin
        w = mem_word(bus.ifu_addr & ~64'h7);
        r.err = 0;
        r.chk_data = 1;
        r.rdata = ((bus.ifu_addr % 64'd8) == 64'd4) ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
        r.gcyc = cyc;
        ifu_q.push_back(r);
        m.addr = bus.ifu_addr & ~64'h7;
        m.wen = 0;
        m.wdata = 64'd0;
        m.wstrb = 8'h00;
        mem_q.push_back(m);
        busy = 1; last_lsu = 0; gnt_log.push_back(1'b0);
      end
      if (prev_stall) chk("mem_req_held", {63'd0, bus.mem_req}, 64'd1);
      if (bus.mem_req) begin
        if (mem_q.size() == 0) chk("mem_req_unexpected", {63'd0, bus.mem_req}, 64'd0);
        else begin
          m = mem_q[0];
          chk("mem_addr", bus.mem_addr, m.addr);
          chk("mem_wen", {63'd0, bus.mem_wen}, {63'd0, m.wen});
          chk("mem_wstrb", {56'd0, bus.mem_wstrb}, {56'd0, m.wstrb});
          if (m.wen) chk("mem_wdata", bus.mem_wdata, m.wdata);
          if (bus.mem_ready) begin
            void'(mem_q.pop_front());
            resp_pending = 1; resp_real = 1; resp_addr = m.addr;
            resp_cnt = $urandom_range(dly_max, dly_min);
          end
        end
      end
      prev_stall = bus.mem_req && !bus.mem_ready;
      stall_run = prev_stall ? stall_run + 1 : 0;
      if (stall_run > max_stall) max_stall = stall_run;
      if (bus.mem_rvalid && !mem_fire) chk("spurious_rvalid_ignored", {63'd0, bus.ifu_rvalid}, 64'd0);
      if (mem_fire) chk("rvalid_on_response", {63'd0, bus.ifu_rvalid | bus.lsu_rvalid}, 64'd1);
      if (bus.ifu_rvalid) begin
        if (ifu_q.size() == 0) chk("ifu_rvalid_unexpected", {63'd0, bus.ifu_rvalid}, 64'd0);
        else begin
          r = ifu_q.pop_front();
          chk("ifu_rdata", {32'd0, bus.ifu_rdata}, r.rdata);
          chk("ifu_rvalid_source", {63'd0, mem_fire}, 64'd1);
          if (chk_lat) chk("ifu_latency", 64'(cyc - r.gcyc), 64'd2);
          busy = 0;
        end
      end
      if (bus.lsu_rvalid) begin
        if (lsu_q.size() == 0) chk("lsu_rvalid_unexpected", {63'd0, bus.lsu_rvalid}, 64'd0);
        else begin
          r = lsu_q.pop_front();
          chk("lsu_err", {63'd0, bus.lsu_err}, {63'd0, r.err});
          if (r.chk_data) chk("lsu_rdata", bus.lsu_rdata, r.rdata);
          if (r.err) chk("err_latency", 64'(cyc - r.gcyc), 64'd1);
          else chk("lsu_rvalid_source", {63'd0, mem_fire}, 64'd1);
          busy = 0;
        end
      end
    end
  end

  task automatic ifu_issue(input logic [63:0] a, input int max_wait, input bit must);
    bit got = 0;
    bus.ifu_req = 1'b1;
    bus.ifu_addr = a;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bus.ifu_gnt) begin got = 1; break; end
    end
    if (must) chk("ifu_gnt_wait", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.ifu_req = 1'b0;
  endtask

  task automatic lsu_issue(input bit wen, input logic [63:0] a, input logic [63:0] wd,
                           input logic [3:0] mk, input int max_wait, input bit must);
    bit got = 0;
    bus.lsu_req = 1'b1;
    bus.lsu_wen = wen;
    bus.lsu_addr = a;
    bus.lsu_wdata = wd;
    bus.lsu_mask = mk;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bus.lsu_gnt) begin got = 1; break; end
    end
    if (must) chk("lsu_gnt_wait", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.lsu_req = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && ifu_q.size() == 0 && lsu_q.size() == 0 && mem_q.size() == 0) break;
    end
    chk("drain_timeout", {63'd0, i < 300}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] ord;
    bus.ifu_req = 1'b1;
    bus.ifu_addr = 64'h8000_0100;
    bus.lsu_req = 1'b1;
    bus.lsu_wen = 1'b0;
    bus.lsu_addr = 64'h8000_0010;
    bus.lsu_wdata = 64'd0;
    bus.lsu_mask = 4'b0001;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesting out of reset, zero-wait memory: L, I, L, I
    fork
      begin
        lsu_issue(0, 64'h8000_0010, 64'd0, 4'b0001, 200, 1);
        lsu_issue(1, 64'h8000_0020, 64'h1122_3344_5566_7788, 4'b0001, 200, 1);
      end
      begin
        ifu_issue(64'h8000_0100, 200, 1);
        ifu_issue(64'h8000_0104, 200, 1);
      end
    join
    drain();
    ord = 4'b0000;
    for (int i = 0; i < 4; i++) if (i < gnt_log.size()) ord = {ord[2:0], gnt_log[i]};
    chk("grant_count", 64'(gnt_log.size()), 64'd4);
    chk("grant_order", {60'd0, ord}, 64'hA);

    // Fetch with upper word selected, fixed two-cycle response
    chk_lat = 1;
    ifu_issue(64'h8000_0004, 50, 1);
    drain();
    chk_lat = 0;

    // Byte store into lane 3
    lsu_issue(1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 4'b1000, 50, 1);
    drain();

    // Misaligned word load
    lsu_issue(0, 64'h8000_0002, 64'd0, 4'b0010, 50, 1);
    drain();

    // Memory stalls for more than five cycles
    max_stall = 0;
    hold_cnt = 8;
    ifu_issue(64'h8000_0008, 50, 1);
    drain();
    chk("stall_observed", {63'd0, max_stall >= 5}, 64'd1);

    // Reset while in LS_WAIT, then a late response
    dly_min = 4; dly_max = 4;
    lsu_issue(0, 64'h8000_0040, 64'd0, 4'b0001, 50, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    dly_min = 0; dly_max = 0;
    ifu_issue(64'h8000_0080, 1, 1);
    drain();

    // Randomized traffic
    ready_pct = 70; dly_min = 0; dly_max = 3; spur_en = 1;
    fork
      for (int k = 0; k < 150; k++) begin
        int gap, n;
        bit wd;
        logic [3:0] mk;
        logic [63:0] a;
        gap = $urandom_range(3);
        repeat (gap) begin @(posedge clk); #1; end
        mk = 4'b0001 << $urandom_range(3);
        if ($urandom_range(9) == 0) mk = 4'($urandom);
        a = 64'h8000_0000 + 64'($urandom_range(255));
        n = size_of(mk);
        if (n > 0 && $urandom_range(2) != 0) a = a - (a % 64'(n));
        wd = $urandom_range(9) == 0;
        lsu_issue($urandom_range(1) == 1, a, {$urandom, $urandom}, mk, wd ? 1 : 400, !wd);
      end
      for (int k = 0; k < 150; k++) begin
        int gap;
        bit wd;
        gap = $urandom_range(3);
        repeat (gap) begin @(posedge clk); #1; end
        wd = $urandom_range(9) == 0;
        ifu_issue(64'h8000_0000 + 64'(4 * $urandom_range(255)), wd ? 1 : 400, !wd);
      end
    join
    spur_en = 0;
    drain();
    chk("ifu_q_empty", 64'(ifu_q.size()), 64'd0);
    chk("lsu_q_empty", 64'(lsu_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
